// File: rtl/vga_pkg.sv
// Shared VGA raster constants, game-state field widths and the sync-window helper.
// Timing values here are the 640x480@60 defaults; the top may override them.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 1;
    localparam logic SYNC_POL_DEF = 1'b0;

    localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int INV_ARRAY_W = 20;
    localparam int INV_LINE_W  = 4;
    localparam int SHIP_X_W    = 5;
    localparam int BULLET_X_W  = 5;
    localparam int BULLET_Y_W  = 4;

    typedef struct packed {
        logic [INV_ARRAY_W-1:0] inv_array;
        logic [INV_LINE_W-1:0]  inv_line;
        logic [SHIP_X_W-1:0]    ship_x;
        logic [BULLET_X_W-1:0]  bullet_x;
        logic [BULLET_Y_W-1:0]  bullet_y;
        logic                   bullet_flying;
    } game_state_t;

    // Half-open window [lo, hi) used for both sync pulses.
    function automatic logic in_window(logic [CNT_W-1:0] v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, carry-out and a registered sync output
// that always describes the count held in the same cycle.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL      = H_TOTAL_DEF,
    parameter int   SYNC_START = H_SYNC_START_DEF,
    parameter int   SYNC_END   = H_SYNC_END_DEF,
    parameter logic SYNC_POL   = SYNC_POL_DEF
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic             carry_o,
    output logic             sync_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;

    assign carry_o = en_i && (cnt_q == CNT_W'(TOTAL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = carry_o ? '0 : cnt_q + CNT_W'(1);
        end
        // Sync is decoded from the next count so it lands in the same cycle as the count.
        sync_d = in_window(cnt_d, SYNC_START, SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q  <= '0;
            sync_q <= ~SYNC_POL;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel prescaler, x/y counters, syncs, display window, and a
// once-per-frame snapshot of the game-state bus taken at the start of vertical blanking.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter int   CLK_DIV  = CLK_DIV_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [INV_ARRAY_W-1:0] invArray_in,
    input  logic [INV_LINE_W-1:0]  invLine_in,
    input  logic [SHIP_X_W-1:0]    shipX_in,
    input  logic [BULLET_X_W-1:0]  bulletX_in,
    input  logic [BULLET_Y_W-1:0]  bulletY_in,
    input  logic                   bulletFlying_in,
    output logic [CNT_W-1:0]       VGAx,
    output logic [CNT_W-1:0]       VGAy,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic                   pix_tick,
    output logic                   frame_tick,
    output logic [INV_ARRAY_W-1:0] invArray,
    output logic [INV_LINE_W-1:0]  invLine,
    output logic [SHIP_X_W-1:0]    shipX,
    output logic [BULLET_X_W-1:0]  bulletX,
    output logic [BULLET_Y_W-1:0]  bulletY,
    output logic                   bulletFlying
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;
    logic [CNT_W-1:0] h_cnt_d, v_cnt_d;
    logic             h_carry, v_carry_unused;
    logic             display_on_q, display_on_d;
    logic             frame_tick_q, frame_tick_d;
    game_state_t      state_q, state_d, state_in;

    always_comb begin
        div_d      = pix_tick_q ? '0 : div_q + DIV_W'(1);
        pix_tick_d = (div_d == DIV_W'(CLK_DIV - 1));
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_h_axis (
        .clk     (clk),
        .clr_i   (clr),
        .en_i    (pix_tick_q),
        .cnt_o   (VGAx),
        .cnt_d_o (h_cnt_d),
        .carry_o (h_carry),
        .sync_o  (hsync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_v_axis (
        .clk     (clk),
        .clr_i   (clr),
        .en_i    (h_carry),
        .cnt_o   (VGAy),
        .cnt_d_o (v_cnt_d),
        .carry_o (v_carry_unused),
        .sync_o  (vsync)
    );

    assign state_in = {invArray_in, invLine_in, shipX_in, bulletX_in, bulletY_in, bulletFlying_in};

    always_comb begin
        display_on_d = (h_cnt_d < CNT_W'(H_ACTIVE)) && (v_cnt_d < CNT_W'(V_ACTIVE));
        // A line wrap out of the last active line is the only way to reach (0, V_ACTIVE).
        frame_tick_d = h_carry && (VGAy == CNT_W'(V_ACTIVE - 1));
        state_d      = frame_tick_d ? state_in : state_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_q        <= '0;
            pix_tick_q   <= (CLK_DIV == 1);
            display_on_q <= 1'b1;
            frame_tick_q <= 1'b0;
            state_q      <= '0;
        end else begin
            div_q        <= div_d;
            pix_tick_q   <= pix_tick_d;
            display_on_q <= display_on_d;
            frame_tick_q <= frame_tick_d;
            state_q      <= state_d;
        end
    end

    assign display_on   = display_on_q;
    assign pix_tick     = pix_tick_q;
    assign frame_tick   = frame_tick_q;
    assign invArray     = state_q.inv_array;
    assign invLine      = state_q.inv_line;
    assign shipX        = state_q.ship_x;
    assign bulletX      = state_q.bullet_x;
    assign bulletY      = state_q.bullet_y;
    assign bulletFlying = state_q.bullet_flying;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two small-geometry instances (CLK_DIV=1 active-low sync, CLK_DIV=2
// active-high sync) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int N_CYCLES   = 6000;
    localparam int RESET_FREE = 3000;

    typedef struct {
        int          x;
        int          y;
        bit          hs;
        bit          vs;
        bit          de;
        bit          pt;
        bit          ft;
        logic [38:0] sh;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic [19:0] inv_array;
    logic [3:0]  inv_line;
    logic [4:0]  ship_x, bullet_x;
    logic [3:0]  bullet_y;
    logic        bullet_flying;

    logic [9:0]  a_x, a_y, b_x, b_y;
    logic        a_hs, a_vs, a_de, a_pt, a_ft, b_hs, b_vs, b_de, b_pt, b_ft;
    logic [19:0] a_inv, b_inv;
    logic [3:0]  a_line, b_line, a_by, b_by;
    logic [4:0]  a_ship, b_ship, a_bx, b_bx;
    logic        a_bf, b_bf;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(1), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .clr(clr),
        .invArray_in(inv_array), .invLine_in(inv_line), .shipX_in(ship_x),
        .bulletX_in(bullet_x), .bulletY_in(bullet_y), .bulletFlying_in(bullet_flying),
        .VGAx(a_x), .VGAy(a_y), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
        .pix_tick(a_pt), .frame_tick(a_ft),
        .invArray(a_inv), .invLine(a_line), .shipX(a_ship), .bulletX(a_bx),
        .bulletY(a_by), .bulletFlying(a_bf)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(2), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .clr(clr),
        .invArray_in(inv_array), .invLine_in(inv_line), .shipX_in(ship_x),
        .bulletX_in(bullet_x), .bulletY_in(bullet_y), .bulletFlying_in(bullet_flying),
        .VGAx(b_x), .VGAy(b_y), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .pix_tick(b_pt), .frame_tick(b_ft),
        .invArray(b_inv), .invLine(b_line), .shipX(b_ship), .bulletX(b_bx),
        .bulletY(b_by), .bulletFlying(b_bf)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // n = clk edges since the last reset edge; everything follows by division.
    function automatic exp_t calc(int n, int cd, bit pol);
        exp_t e;
        int   p = n / cd;
        int   d = n % cd;
        e.x  = p % HT;
        e.y  = (p / HT) % VT;
        e.pt = (d == cd - 1);
        e.hs = (e.x >= HA + HF && e.x < HA + HF + HS) ? pol : !pol;
        e.vs = (e.y >= VA + VF && e.y < VA + VF + VS) ? pol : !pol;
        e.de = (e.x < HA) && (e.y < VA);
        e.ft = (d == 0) && (e.x == 0) && (e.y == VA);
        e.sh = '0;
        return e;
    endfunction

    task automatic cmp(string tag, exp_t e, logic [9:0] x, logic [9:0] y, logic hs, logic vs,
                       logic de, logic pt, logic ft, logic [38:0] sh);
        check({tag, ".VGAx"}, 64'(x), 64'(e.x));
        check({tag, ".VGAy"}, 64'(y), 64'(e.y));
        check({tag, ".hsync"}, 64'(hs), 64'(e.hs));
        check({tag, ".vsync"}, 64'(vs), 64'(e.vs));
        check({tag, ".display_on"}, 64'(de), 64'(e.de));
        check({tag, ".pix_tick"}, 64'(pt), 64'(e.pt));
        check({tag, ".frame_tick"}, 64'(ft), 64'(e.ft));
        check({tag, ".shadow"}, 64'(sh), 64'(e.sh));
    endtask

    task automatic drive_random();
        inv_array     = 20'($urandom);
        inv_line      = 4'($urandom);
        ship_x        = 5'($urandom);
        bullet_x      = 5'($urandom);
        bullet_y      = 4'($urandom);
        bullet_flying = 1'($urandom);
    endtask

    // Stimulus + reference model: at each edge, push the state the DUTs must now hold.
    initial begin
        int          n_a = 0, n_b = 0;
        logic [38:0] sh_a = '0, sh_b = '0;
        logic [38:0] in_vec;
        exp_t        e;
        clr = 1'b1;
        drive_random();
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            in_vec = {inv_array, inv_line, ship_x, bullet_x, bullet_y, bullet_flying};
            if (clr) begin
                n_a = 0; n_b = 0; sh_a = '0; sh_b = '0;
            end else begin
                n_a++; n_b++;
            end
            e = calc(n_a, 1, 1'b0);
            if (e.ft) sh_a = in_vec;
            e.sh = sh_a;
            q_a.push_back(e);
            e = calc(n_b, 2, 1'b1);
            if (e.ft) sh_b = in_vec;
            e.sh = sh_b;
            q_b.push_back(e);
            #1;
            clr = (cyc == 3100) || (cyc >= 4500 && cyc < 4503) ||
                  (cyc > RESET_FREE && $urandom_range(0, 699) == 0);
            if ($urandom_range(0, 1) == 1) drive_random();
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: pops and compares on every falling edge, plus reset-free frame spacing.
    initial begin
        int   mon_cyc = 0;
        int   last_a = -1, last_b = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp("a", e, a_x, a_y, a_hs, a_vs, a_de, a_pt, a_ft,
                    {a_inv, a_line, a_ship, a_bx, a_by, a_bf});
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                cmp("b", e, b_x, b_y, b_hs, b_vs, b_de, b_pt, b_ft,
                    {b_inv, b_line, b_ship, b_bx, b_by, b_bf});
            end
            if (a_ft === 1'b1 && mon_cyc < RESET_FREE) begin
                if (last_a >= 0) check("a.frame_period", 64'(mon_cyc - last_a), 64'(HT * VT));
                last_a = mon_cyc;
            end
            if (b_ft === 1'b1 && mon_cyc < RESET_FREE) begin
                if (last_b >= 0) check("b.frame_period", 64'(mon_cyc - last_b), 64'(HT * VT * 2));
                last_b = mon_cyc;
            end
        end
    end

endmodule
